cm163_slice_arbiter: RTL and testbench
======================================

// Module: cm163_slice_arbiter
// PURPOSE
//  Time-shares one 4-bit loadable synchronous counter slice (cm163 next-state logic) among
//  NREQ requesters, each owning a private 4-bit counter register. Round-robin arbiter grants
//  one op per cycle; slice evaluates it and writes back. Sits between control requesters and
//  the shared counter datapath; replaces NREQ replicated slices.
// PARAMETERS
//  NREQ   4   number of requesters / counter channels (2..8)
//  IDW    2   width of rsp_id, = clog2(NREQ)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       synchronous reset, active-low
//  req_valid  in   NREQ    per-requester op request
//  req_op     in   2*NREQ  op per requester, slice i at [2i+1:2i]
//  req_data   in   4*NREQ  load data per requester, slice i at [4i+3:4i]
//  req_ready  out  NREQ    one-hot grant; op accepted when valid&ready
//  cnt_en     in   1       global count enable (slice enable term)
//  rsp_valid  out  1       result of an accepted op is present
//  rsp_id     out  IDW     channel of the result
//  rsp_value  out  4       counter value after the op
//  rsp_tc     out  1       terminal count: COUNT wrapped 15->0
//  cnt_q      out  4*NREQ  all counter registers, flat, observation only
// BEHAVIOUR
//  - Ops: CLEAR=2'b00 (value<=0), LOAD=2'b01 (value<=data), COUNT=2'b10 (value<=value+1 mod 16
//    if cnt_en, else hold), READ=2'b11 (no change, returns value).
//  - Stage A (cycle t): combinational round-robin over req_valid starting at rr_ptr; at most
//    one req_ready bit high, only for a valid requester; op/id/data captured into stage reg.
//    rr_ptr <= granted_id+1 (mod NREQ) on grant; unchanged with no grant.
//  - Stage B (cycle t+1): slice computes next value from captured op, data, cnt_en sampled
//    at cycle t, and current counter; counter written at end of t+1; rsp_* valid during t+1
//    (one-cycle latency accept->response, rsp_valid is a 1-cycle pulse per op).
//  - Back-to-back ops on same channel: op accepted at t+1 reads value written at end of t+1;
//    no stall, no bypass mux needed beyond register read in stage B.
//  - rsp_tc=1 only for COUNT with cnt_en=1 and old value 4'hF; 0 for all other ops.
//  - No backpressure on rsp; consumer must accept every pulse. Requester holds valid/op/data
//    until ready. Full throughput: one op per cycle aggregate.
//  - rsp_id/rsp_value/rsp_tc hold last values when rsp_valid=0.
//  - Reset (rst_n=0 at an edge): all counters 4'h0, rr_ptr=0, stage reg invalid, rsp_valid=0,
//    rsp_id=0, rsp_value=0, rsp_tc=0; req_ready forced 0 while rst_n=0. Op in flight during
//    reset is dropped, no response. First grant after reset favours requester 0.
//  - req_op/req_data of non-granted requesters ignored; X on them must not propagate.
// STRUCTURE
//  - cm163_pkg: op enum (CLEAR/LOAD/COUNT/READ), SLICE_W=4, TC_VALUE=4'hF.
//  - Sub-module cm163_slice: pure combinational next-state (op, data, cur, en) -> (nxt, tc);
//    reusable standalone and checked against the golden cm163 function.
//  - Top: rr arbiter, stage register, counter register array, write-back, outputs.
// TESTING
//  - Reset: hold rst_n=0 2 cycles with all req_valid=1 -> req_ready=0, rsp_valid=0, cnt_q=0.
//  - LOAD ch1 data 4'hA -> next cycle rsp_valid=1, rsp_id=1, rsp_value=4'hA, cnt_q[7:4]=4'hA.
//  - ch2 LOAD 4'hE then COUNT x3 back-to-back, cnt_en=1 -> rsp_value F,0,1; rsp_tc=1 on 0 only.
//  - All 4 valid COUNT every cycle -> grants 0,1,2,3,0 in order; each counter +1 per 4 cycles.
//  - COUNT with cnt_en=0 on value 4'h7 -> rsp_value=4'h7, rsp_tc=0; CLEAR -> rsp_value=0.
//  - Assert rst_n=0 cycle after accepting LOAD 4'h5 -> no rsp pulse, counter stays 0.

Source files
------------

// File: rtl/cm163_pkg.sv
// rtl/cm163_pkg.sv - shared op encoding and slice constants for the cm163 counter slice
package cm163_pkg;

    localparam int SLICE_W = 4;
    localparam logic [SLICE_W-1:0] TC_VALUE = 4'hF;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'b00,
        OP_LOAD  = 2'b01,
        OP_COUNT = 2'b10,
        OP_READ  = 2'b11
    } op_t;

endpackage

// File: rtl/cm163_slice_arbiter_if.sv
// rtl/cm163_slice_arbiter_if.sv - requester/response bundle of the shared counter slice
interface cm163_slice_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [2*NREQ-1:0] req_op;
    logic [4*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              cnt_en;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [3:0]        rsp_value;
    logic              rsp_tc;
    logic [4*NREQ-1:0] cnt_q;

    modport master (
        output req_valid, req_op, req_data, cnt_en,
        input  req_ready, rsp_valid, rsp_id, rsp_value, rsp_tc, cnt_q
    );

    modport slave (
        input  req_valid, req_op, req_data, cnt_en,
        output req_ready, rsp_valid, rsp_id, rsp_value, rsp_tc, cnt_q
    );
endinterface

// File: rtl/cm163_slice.sv
// rtl/cm163_slice.sv - combinational next-state of one 4-bit loadable counter slice
module cm163_slice
    import cm163_pkg::*;
(
    input  op_t                op,
    input  logic [SLICE_W-1:0] data,
    input  logic [SLICE_W-1:0] cur,
    input  logic               en,
    output logic [SLICE_W-1:0] nxt,
    output logic               tc
);

    always_comb begin
        nxt = cur;
        tc  = 1'b0;
        case (op)
            OP_CLEAR: nxt = '0;
            OP_LOAD:  nxt = data;
            OP_COUNT: begin
                if (en) begin
                    nxt = cur + SLICE_W'(1);
                    tc  = (cur == TC_VALUE);
                end
            end
            default:  nxt = cur;
        endcase
    end

endmodule

// File: rtl/cm163_slice_arbiter.sv
// rtl/cm163_slice_arbiter.sv - round-robin time-sharing of one cm163 slice over NREQ counters
module cm163_slice_arbiter
    import cm163_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cm163_slice_arbiter_if.slave  bus
);

    logic [IDW-1:0]     rr_ptr;
    logic [NREQ-1:0]    grant;
    logic [IDW-1:0]     gnt_id;
    logic               found;
    int                 idx;

    logic               st_valid;
    op_t                st_op;
    logic [IDW-1:0]     st_id;
    logic [SLICE_W-1:0] st_data;
    logic               st_en;

    logic [SLICE_W-1:0] cnt [NREQ];
    logic [SLICE_W-1:0] cur;
    logic [SLICE_W-1:0] nxt;
    logic               tc;
    logic               rsp_fire;

    logic [IDW-1:0]     rsp_id_q;
    logic [SLICE_W-1:0] rsp_value_q;
    logic               rsp_tc_q;

    // First valid requester at or after rr_ptr wins; nothing is granted in reset.
    always_comb begin
        grant  = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!found && bus.req_valid[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                gnt_id      = IDW'(idx);
            end
        end
        if (!rst_n) begin
            grant = '0;
            found = 1'b0;
        end
    end

    assign bus.req_ready = grant;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            st_valid <= 1'b0;
            st_op    <= OP_CLEAR;
            st_id    <= '0;
            st_data  <= '0;
            st_en    <= 1'b0;
        end else begin
            st_valid <= found;
            if (found) begin
                st_op   <= op_t'(bus.req_op[2*int'(gnt_id) +: 2]);
                st_id   <= gnt_id;
                st_data <= bus.req_data[4*int'(gnt_id) +: 4];
                st_en   <= bus.cnt_en;
                rr_ptr  <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);
            end
        end
    end

    assign cur = cnt[st_id];

    cm163_slice u_slice (
        .op   (st_op),
        .data (st_data),
        .cur  (cur),
        .en   (st_en),
        .nxt  (nxt),
        .tc   (tc)
    );

    // An op still in the stage register when reset arrives is dropped silently.
    assign rsp_fire = st_valid && rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                cnt[i] <= '0;
            end
            rsp_id_q    <= '0;
            rsp_value_q <= '0;
            rsp_tc_q    <= 1'b0;
        end else if (st_valid) begin
            cnt[st_id]  <= nxt;
            rsp_id_q    <= st_id;
            rsp_value_q <= nxt;
            rsp_tc_q    <= tc;
        end
    end

    assign bus.rsp_valid = rsp_fire;
    assign bus.rsp_id    = rsp_fire ? st_id : rsp_id_q;
    assign bus.rsp_value = rsp_fire ? nxt   : rsp_value_q;
    assign bus.rsp_tc    = rsp_fire ? tc    : rsp_tc_q;

    for (genvar i = 0; i < NREQ; i++) begin : g_cnt_q
        assign bus.cnt_q[4*i +: 4] = cnt[i];
    end

endmodule

// File: tb/tb_cm163_slice_arbiter.sv
// tb/tb_cm163_slice_arbiter.sv - scoreboard bench for the shared cm163 slice arbiter
module tb_cm163_slice_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic clk;
    logic rst_n;

    cm163_slice_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    cm163_slice_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int id;
        int value;
        int tc;
    } rsp_t;

    rsp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int   m_cnt [NREQ];
    int   m_ptr;
    bit   pending;
    int   pend_id;
    int   pend_old;
    bit   rst_seen;
    rsp_t last;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
            chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            if (rst_seen) begin
                chk("rst_cnt_q", 32'(bus.cnt_q), 32'd0);
                chk("rst_rsp_value", 32'(bus.rsp_value), 32'd0);
                chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
            end
            for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
            m_ptr    = 0;
            pending  = 1'b0;
            sb.delete();
            last     = '{0, 0, 0};
            rst_seen = 1'b1;
        end else begin
            logic [4*NREQ-1:0] exp_flat;
            logic [NREQ-1:0]   exp_g;
            int                gid;
            rst_seen = 1'b0;

            exp_flat = '0;
            for (int i = 0; i < NREQ; i++) begin
                exp_flat[4*i +: 4] = 4'((pending && pend_id == i) ? pend_old : m_cnt[i]);
            end
            chk("cnt_q", 32'(bus.cnt_q), 32'(exp_flat));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(pending));

            if (bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    rsp_t e;
                    e = sb.pop_front();
                    chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                    chk("rsp_value", 32'(bus.rsp_value), 32'(e.value));
                    chk("rsp_tc", 32'(bus.rsp_tc), 32'(e.tc));
                    last = e;
                end
            end else begin
                chk("hold_id", 32'(bus.rsp_id), 32'(last.id));
                chk("hold_value", 32'(bus.rsp_value), 32'(last.value));
                chk("hold_tc", 32'(bus.rsp_tc), 32'(last.tc));
            end

            gid   = -1;
            exp_g = '0;
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (gid < 0 && bus.req_valid[i]) gid = i;
            end
            if (gid >= 0) exp_g[gid] = 1'b1;
            chk("grant", 32'(bus.req_ready), 32'(exp_g));

            if (gid >= 0) begin
                int   op;
                int   nv;
                int   t;
                rsp_t e;
                op = int'(bus.req_op[2*gid +: 2]);
                nv = m_cnt[gid];
                t  = 0;
                case (op)
                    0: nv = 0;
                    1: nv = int'(bus.req_data[4*gid +: 4]);
                    2: if (bus.cnt_en) begin
                           nv = (m_cnt[gid] + 1) % 16;
                           t  = (m_cnt[gid] == 15) ? 1 : 0;
                       end
                    default: nv = m_cnt[gid];
                endcase
                e = '{gid, nv, t};
                sb.push_back(e);
                pending  = 1'b1;
                pend_id  = gid;
                pend_old = m_cnt[gid];
                m_cnt[gid] = nv;
                m_ptr = (gid + 1) % NREQ;
            end else begin
                pending = 1'b0;
            end
        end
    end

    task automatic do_op(input int ch, input logic [1:0] op, input logic [3:0] data);
        int n;
        bus.req_op[2*ch +: 2]   = op;
        bus.req_data[4*ch +: 4] = data;
        bus.req_valid[ch]       = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.req_ready[ch]) break;
            n++;
            if (n > 20) begin
                chk("grant_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid[ch] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = '1;
        bus.req_op    = '0;
        bus.req_data  = '0;
        bus.cnt_en    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // every requester counting, grants rotate from 0
        bus.cnt_en    = 1'b1;
        bus.req_op    = {NREQ{2'b10}};
        bus.req_valid = '1;
        idle(9);
        bus.req_valid = '0;
        idle(2);

        do_op(1, 2'b01, 4'hA);
        idle(2);

        do_op(2, 2'b01, 4'hE);
        do_op(2, 2'b10, 4'h0);
        do_op(2, 2'b10, 4'h0);
        do_op(2, 2'b10, 4'h0);
        idle(2);

        do_op(3, 2'b01, 4'h7);
        bus.cnt_en = 1'b0;
        do_op(3, 2'b10, 4'h0);
        do_op(3, 2'b11, 4'h0);
        bus.cnt_en = 1'b1;
        do_op(3, 2'b00, 4'h9);
        idle(2);

        // reset lands while the LOAD sits in the stage register
        bus.req_op[1:0]   = 2'b01;
        bus.req_data[3:0] = 4'h5;
        bus.req_valid[0]  = 1'b1;
        @(negedge clk);
        chk("inflight_grant", 32'(bus.req_ready[0]), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(2);

        bus.req_op    = {NREQ{2'b11}};
        bus.req_valid = '1;
        idle(5);
        bus.req_valid = '0;
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
